serial_pattern_matcher: RTL and testbench

Parametrised serial pattern matcher, the successor to the fixed 3-bit serial pattern detector. It shifts a serial bit stream into a PATTERN_W-bit window and compares the window against a runtime-loadable pattern under a bit mask. Overlapping or non-overlapping matching is selectable, and an optional saturating match counter is available. It sits on the serial ingress path and produces a one-cycle registered detect pulse for downstream framing and statistics logic.

---
 rtl/serial_pattern_matcher.sv | 122 ++++++++++++
 tb/tb_serial_pattern_matcher.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_matcher.sv
// Serial pattern matcher: shifts a bit stream into a PATTERN_W window and flags masked matches.
// Optional saturating match counter compiled in with `define PATTERN_MATCH_COUNT_EN.
module serial_pattern_matcher #(
   parameter int unsigned PATTERN_W = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 serial_pattern,
   input  logic                 cfg_load,
   input  logic [PATTERN_W-1:0] cfg_pattern,
   input  logic [PATTERN_W-1:0] cfg_mask,
   input  logic                 cfg_overlap,
   input  logic                 count_clear,
   output logic                 pattern_detected,
   output logic [CNT_W-1:0]     match_count
);

   localparam int unsigned FILL_W = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ARMED
   } state_e;

   state_e state;

   logic [PATTERN_W-1:0] win_q, win_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [PATTERN_W-1:0] pat_q, pat_d;
   logic [PATTERN_W-1:0] msk_q, msk_d;
   logic                 ovl_q, ovl_d;
   logic                 det_q, det_d;

   logic [PATTERN_W-1:0] win_n;
   logic [FILL_W-1:0]    fill_n;
   logic                 hit;

   // State is a view of fill/enable rather than a separate register.
   always_comb begin
      if (!enable)                 state = IDLE;
      else if (fill_q == FILL_FULL) state = ARMED;
      else                         state = FILL;
   end

   always_comb begin
      win_d  = win_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      msk_d  = msk_q;
      ovl_d  = ovl_q;
      det_d  = 1'b0;
      win_n  = {win_q[PATTERN_W-2:0], serial_pattern};
      fill_n = (state == ARMED) ? FILL_FULL : fill_q + 1'b1;
      hit    = (fill_n == FILL_FULL) && (((win_n ^ pat_q) & msk_q) == '0);

      if (cfg_load) begin
         pat_d  = cfg_pattern;
         msk_d  = cfg_mask;
         ovl_d  = cfg_overlap;
         fill_d = '0;
      end else begin
         case (state)
            IDLE: fill_d = '0;
            FILL, ARMED: begin
               win_d  = win_n;
               det_d  = hit;
               fill_d = (hit && !ovl_q) ? '0 : fill_n;
            end
            default: fill_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q  <= '0;
         fill_q <= '0;
         pat_q  <= '0;
         msk_q  <= '1;
         ovl_q  <= 1'b1;
         det_q  <= 1'b0;
      end else begin
         win_q  <= win_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         msk_q  <= msk_d;
         ovl_q  <= ovl_d;
         det_q  <= det_d;
      end
   end

   assign pattern_detected = det_q;

`ifdef PATTERN_MATCH_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear beats a same-cycle increment; saturate instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (count_clear)
         cnt_d = '0;
      else if (det_d && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign match_count = cnt_q;
`else
   logic unused_count_clear;
   assign unused_count_clear = count_clear;
   assign match_count        = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Scoreboard bench for serial_pattern_matcher: a bit-queue reference model predicts each cycle's outputs.
module tb_serial_pattern_matcher;

   localparam int unsigned PW = 8;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          serial_pattern;
   logic          cfg_load;
   logic [PW-1:0] cfg_pattern;
   logic [PW-1:0] cfg_mask;
   logic          cfg_overlap;
   logic          count_clear;
   logic          pattern_detected;
   logic [CW-1:0] match_count;

   serial_pattern_matcher #(.PATTERN_W(PW), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .serial_pattern   (serial_pattern),
      .cfg_load         (cfg_load),
      .cfg_pattern      (cfg_pattern),
      .cfg_mask         (cfg_mask),
      .cfg_overlap      (cfg_overlap),
      .count_clear      (count_clear),
      .pattern_detected (pattern_detected),
      .match_count      (match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          det;
      logic [CW-1:0] cnt;
      int            idx;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pulses = 0;
   int   cyc_idx = 0;

   // Reference model: bits accepted since the last restart, plus captured config.
   bit            fresh[$];
   logic [PW-1:0] m_pat;
   logic [PW-1:0] m_msk;
   bit            m_ovl;
   int            m_cnt;

   function automatic bit window_hit();
      if (fresh.size() < PW) return 1'b0;
      for (int i = 0; i < PW; i++) begin
         if (m_msk[i] && (fresh[fresh.size() - 1 - i] != m_pat[i])) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      fresh.delete();
      m_pat = '0;
      m_msk = '1;
      m_ovl = 1'b1;
      m_cnt = 0;
   endtask

   task automatic check(input string name, input int actual, input int required);
      total++;
      if (actual != required) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, required, $time);
      end
   endtask

   task automatic drive(input bit en, input bit din, input bit ld, input logic [PW-1:0] p,
                        input logic [PW-1:0] m, input bit o, input bit clr);
      exp_t e;
      bit   hit;
      @(negedge clk);
      enable         = en;
      serial_pattern = din;
      cfg_load       = ld;
      cfg_pattern    = p;
      cfg_mask       = m;
      cfg_overlap    = o;
      count_clear    = clr;
      hit = 1'b0;
      if (ld) begin
         m_pat = p;
         m_msk = m;
         m_ovl = o;
         fresh.delete();
      end else if (!en) begin
         fresh.delete();
      end else begin
         fresh.push_back(din);
         if (fresh.size() > PW) void'(fresh.pop_front());
         hit = window_hit();
         if (hit && !m_ovl) fresh.delete();
      end
      if (clr) m_cnt = 0;
      else if (hit && (m_cnt < (1 << CW) - 1)) m_cnt++;
      e.det = hit;
`ifdef PATTERN_MATCH_COUNT_EN
      e.cnt = CW'(m_cnt);
`else
      e.cnt = '0;
`endif
      e.idx = cyc_idx++;
      exp_q.push_back(e);
   endtask

   task automatic send(input bit en, input bit din, input bit clr);
      drive(en, din, 1'b0, '0, '0, 1'b0, clr);
   endtask

   task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m, input bit o);
      drive(1'b0, 1'b0, 1'b1, p, m, o, 1'b1);
   endtask

   task automatic send_byte(input logic [PW-1:0] b);
      for (int i = PW - 1; i >= 0; i--) send(1'b1, b[i], 1'b0);
   endtask

   task automatic flush();
      repeat (2) send(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
   endtask

   task automatic check_pulses(input string name, input int required);
      check(name, pulses, required);
      pulses = 0;
   endtask

   task automatic go_idle();
      enable      = 1'b0;
      cfg_load    = 1'b0;
      count_clear = 1'b0;
   endtask

   // Monitor: every cycle the DUT presents a result; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (pattern_detected) pulses++;
            check($sformatf("det[%0d]", e.idx), int'(pattern_detected), int'(e.det));
            check($sformatf("cnt[%0d]", e.idx), int'(match_count), int'(e.cnt));
         end
      end
   end

   initial begin
      logic [PW-1:0] rp;
      logic [PW-1:0] rm;
      rst = 1'b1;
      serial_pattern = 1'b0;
      cfg_pattern = '0;
      cfg_mask = '0;
      cfg_overlap = 1'b0;
      go_idle();
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_det", int'(pattern_detected), 0);
      check("reset_cnt", int'(match_count), 0);
      rst = 1'b0;

      // Exact match
      load(8'hA5, 8'hFF, 1'b1);
      send_byte(8'hA5);
      flush();
      check_pulses("exact_pulses", 1);

      // Overlap vs non-overlap on 1010101010
      load(8'hAA, 8'hFF, 1'b1);
      for (int i = 0; i < 10; i++) send(1'b1, ((i % 2) == 0), 1'b0);
      flush();
      check_pulses("ovl1_pulses", 2);
      load(8'hAA, 8'hFF, 1'b0);
      for (int i = 0; i < 10; i++) send(1'b1, ((i % 2) == 0), 1'b0);
      flush();
      check_pulses("ovl0_pulses", 1);

      // Masked compare
      load(8'h0F, 8'h0F, 1'b0);
      send_byte(8'h3F);
      send_byte(8'hCF);
      send_byte(8'h3E);
      flush();
      check_pulses("mask_pulses", 2);

      // Enable drop restarts the fill
      load(8'hA5, 8'hFF, 1'b1);
      send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b0, 1'b0);
      repeat (3) send(1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b1, 1'b0);
      flush();
      check_pulses("endrop_pulses", 0);
      send_byte(8'hA5);
      flush();
      check_pulses("endrop_full_pulses", 1);

      // Counter saturation and clear-on-hit
      load(8'hA5, 8'hFF, 1'b1);
      repeat (5) send_byte(8'hA5);
      flush();
      check_pulses("sat_pulses", 5);
`ifdef PATTERN_MATCH_COUNT_EN
      check("sat_cnt", int'(match_count), 3);
`else
      check("sat_cnt", int'(match_count), 0);
`endif
      for (int i = PW - 1; i >= 1; i--) send(1'b1, ((8'hA5 >> i) & 1) != 0, 1'b0);
      send(1'b1, 1'b1, 1'b1);
      flush();
      check_pulses("clr_hit_pulses", 1);
      check("clr_hit_cnt", int'(match_count), 0);

      // Asynchronous reset while a pulse is showing
      send_byte(8'hA5);
      @(posedge clk);
      #3;
      check("pre_rst_det", int'(pattern_detected), 1);
      rst = 1'b1;
      #1;
      check("async_rst_det", int'(pattern_detected), 0);
      check("async_rst_cnt", int'(match_count), 0);
      go_idle();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      pulses = 0;

      // Reset config is pattern 0 / full mask / overlap
      repeat (PW) send(1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      flush();
      check_pulses("rst_cfg_pulses", 1);

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) < 2) begin
            rp = PW'($urandom);
            rm = ($urandom_range(9) == 0) ? '0 : PW'($urandom & $urandom & $urandom);
            drive(($urandom_range(1) == 1), 1'b0, 1'b1, rp, rm, ($urandom_range(1) == 1),
                  ($urandom_range(99) < 3));
         end else begin
            send(($urandom_range(99) < 85), ($urandom_range(1) == 1), ($urandom_range(99) < 3));
         end
      end
      flush();
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
